// File: rtl/usart_frame_recv_if.sv
// Serial input and decoded frame outputs of usart_frame_recv.
// master = the receiver (drives frame fields), slave = the line driver / frame consumer.
interface usart_frame_recv_if;
    logic        uart_rxd;
    logic [23:0] D;
    logic [1:0]  Adress;
    logic [5:0]  Mod_SEL;
    logic        frame_valid;
    logic        frame_err;

    modport master (
        input  uart_rxd,
        output D, Adress, Mod_SEL, frame_valid, frame_err
    );

    modport slave (
        output uart_rxd,
        input  D, Adress, Mod_SEL, frame_valid, frame_err
    );
endinterface

// File: rtl/usart_frame_recv.sv
// UART byte receiver plus 7-byte frame parser (FF, addr, mode, D2, D1, D0, AA).
// Optional inter-byte timeout enabled by defining USART_FRAME_TIMEOUT_EN.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | counting to the start-bit centre; high there is a glitch
// RX_DATA  | sampling 8 data bits, LSB first, one per bit period
// RX_STOP  | sampling the stop bit; high = byte_ok, low = framing error
// P_HUNT   | waiting for the 8'hFF header
// P_ADDR   | next byte is the address
// P_MOD    | next byte is the mode select
// P_DH..DL | next byte is payload bits 23:16 / 15:8 / 7:0
// P_TAIL   | next byte must be 8'hAA to commit the frame
module usart_frame_recv #(
    parameter logic [15:0] BPS_CNT = 16'd434
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    usart_frame_recv_if.master  bus
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HUNT, P_ADDR, P_MOD, P_DH, P_DM, P_DL, P_TAIL} p_state_t;

    localparam logic [15:0] BIT_LOAD  = BPS_CNT - 16'd1;
    localparam logic [15:0] HALF_LOAD = (BPS_CNT >> 1) - 16'd1;

    rx_state_t   rx_state, rx_next;
    p_state_t    p_state, p_next;
    logic        rxd_meta, rxd_sync, rxd_prev;
    logic        fall, tick;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_byte;
    logic        byte_ok, stop_err;
    logic        frame_ok_c, frame_bad_c;
    logic        timeout_hit;
    logic [1:0]  sh_addr;
    logic [5:0]  sh_mod;
    logic [23:0] sh_data;

    // rxd_prev only feeds edge detection; it is not part of the synchronizer
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= bus.uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign fall = rxd_prev & ~rxd_sync;
    assign tick = (cnt == 16'd0);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) rx_state <= RX_IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (fall) rx_next = RX_START;
            RX_START: if (tick) rx_next = rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_ok  = (rx_state == RX_STOP) && tick && rxd_sync;
        stop_err = (rx_state == RX_STOP) && tick && !rxd_sync;
    end

    // Bit timer preloads the half period while idle so START needs no extra load cycle
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            rx_byte <= 8'd0;
        end else if (rx_state == RX_IDLE) begin
            cnt     <= HALF_LOAD;
            bit_idx <= 3'd0;
        end else begin
            cnt <= tick ? BIT_LOAD : cnt - 16'd1;
            if (rx_state == RX_DATA && tick) begin
                rx_byte <= {rxd_sync, rx_byte[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

`ifdef USART_FRAME_TIMEOUT_EN
    localparam logic [20:0] TO_LOAD = 21'(20 * 32'(BPS_CNT) - 1);
    logic [20:0] to_cnt;
    logic        to_run;

    assign to_run      = (p_state != P_HUNT) && (rx_state == RX_IDLE);
    assign timeout_hit = to_run && (to_cnt == 21'd0);

    always_ff @(posedge sys_clk) begin
        if (sys_rst)                         to_cnt <= 21'd0;
        else if (byte_ok)                    to_cnt <= TO_LOAD;
        else if (to_run && to_cnt != 21'd0)  to_cnt <= to_cnt - 21'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) p_state <= P_HUNT;
        else         p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        if (stop_err || timeout_hit) begin
            p_next = P_HUNT;
        end else if (byte_ok) begin
            case (p_state)
                P_HUNT:  p_next = (rx_byte == 8'hFF) ? P_ADDR : P_HUNT;
                P_ADDR:  p_next = P_MOD;
                P_MOD:   p_next = P_DH;
                P_DH:    p_next = P_DM;
                P_DM:    p_next = P_DL;
                P_DL:    p_next = P_TAIL;
                default: p_next = P_HUNT;
            endcase
        end
    end

    // stop_err/timeout never coincide with byte_ok, so the two pulses are exclusive
    always_comb begin
        frame_ok_c  = byte_ok && (p_state == P_TAIL) && (rx_byte == 8'hAA);
        frame_bad_c = stop_err || timeout_hit ||
                      (byte_ok && (p_state == P_TAIL) && (rx_byte != 8'hAA));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sh_addr         <= 2'd0;
            sh_mod          <= 6'd0;
            sh_data         <= 24'd0;
            bus.D           <= 24'd0;
            bus.Adress      <= 2'd0;
            bus.Mod_SEL     <= 6'd0;
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            if (byte_ok) begin
                case (p_state)
                    P_ADDR:  sh_addr        <= rx_byte[1:0];
                    P_MOD:   sh_mod         <= rx_byte[5:0];
                    P_DH:    sh_data[23:16] <= rx_byte;
                    P_DM:    sh_data[15:8]  <= rx_byte;
                    P_DL:    sh_data[7:0]   <= rx_byte;
                    default: ;
                endcase
            end
            if (frame_ok_c) begin
                bus.D       <= sh_data;
                bus.Adress  <= sh_addr;
                bus.Mod_SEL <= sh_mod;
            end
            bus.frame_valid <= frame_ok_c;
            bus.frame_err   <= frame_bad_c;
        end
    end
endmodule
